riscv_alu_sig_checker: RTL and testbench

Response-side companion to the ALU stimulus path: consumes a stream of ALU vectors (op, operands, result) and compacts them into a 32-bit MISR signature. After a programmed number of vectors, it compares the signature against an expected value and reports pass/fail. It sits beside riscv_alu for hardware self-test and regression signature capture.

---
 rtl/riscv_alu_sig_checker.sv | 82 ++++++++
 tb/tb_riscv_alu_sig_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_sig_checker.sv
// riscv_alu_sig_checker: compacts ALU vectors into a 32-bit MISR and checks it against a golden signature.
// Optional ALU_SIG_OPMASK_EN adds op_mask_i so masked opcodes are counted but not folded.
module riscv_alu_sig_checker #(
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter int          CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] vec_count_i,
    input  logic [31:0]      seed_i,
    input  logic [31:0]      expected_sig_i,
`ifdef ALU_SIG_OPMASK_EN
    input  logic [15:0]      op_mask_i,
`endif
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [31:0]      alu_a_i,
    input  logic [31:0]      alu_b_i,
    input  logic [31:0]      alu_p_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [31:0]      signature_o,
    output logic [CNT_W-1:0] vec_done_o
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [31:0]      sig, expected, w, sig_upd, sig_nxt;
    logic [CNT_W-1:0] cnt, count, cnt_inc;
    logic             pass, accept, fold;
`ifdef ALU_SIG_OPMASK_EN
    logic [15:0]      mask;
    assign fold = mask[alu_op_i];
`else
    assign fold = 1'b1;
`endif
    assign w       = alu_p_i ^ {alu_a_i[30:0], alu_a_i[31]} ^ alu_b_i ^ {28'b0, alu_op_i};
    assign sig_upd = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ w;
    assign sig_nxt = fold ? sig_upd : sig;
    assign cnt_inc = cnt + CNT_W'(1);
    // ready_o decodes only the state register, so it never depends on valid_i
    assign ready_o     = state == RUN;
    assign busy_o      = state == RUN;
    assign done_o      = state == DONE;
    assign accept      = valid_i && ready_o;
    assign pass_o      = pass;
    assign signature_o = sig;
    assign vec_done_o  = cnt;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            sig      <= '0;
            expected <= '0;
            count    <= '0;
            cnt      <= '0;
            pass     <= 1'b0;
`ifdef ALU_SIG_OPMASK_EN
            mask     <= '0;
`endif
        end else if (start_i && state != RUN) begin
            sig      <= seed_i;
            cnt      <= '0;
            expected <= expected_sig_i;
            count    <= vec_count_i;
            state    <= (vec_count_i != '0) ? RUN : DONE;
            pass     <= (vec_count_i == '0) && (seed_i == expected_sig_i);
`ifdef ALU_SIG_OPMASK_EN
            mask     <= op_mask_i;
`endif
        end else if (accept) begin
            sig <= sig_nxt;
            cnt <= cnt_inc;
            // pass uses the next-state signature so it is valid as done_o rises
            if (cnt_inc == count) begin
                state <= DONE;
                pass  <= sig_nxt == expected;
            end
        end
    end
endmodule

// File: tb/tb_riscv_alu_sig_checker.sv
// tb_riscv_alu_sig_checker: randomized self-checking bench against a behavioural MISR model.
module tb_riscv_alu_sig_checker;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] vec_count_i = '0;
    logic [31:0] seed_i = '0, expected_sig_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, busy_o, done_o, pass_o;
    logic [3:0]  alu_op_i = '0;
    logic [31:0] alu_a_i = '0, alu_b_i = '0, alu_p_i = '0;
    logic [31:0] signature_o;
    logic [15:0] vec_done_o;
    logic [15:0] mask_r = 16'hFFFF;
    int checks = 0, errors = 0;
`ifdef ALU_SIG_OPMASK_EN
    logic [15:0] op_mask;
    assign op_mask = mask_r;
`endif

    riscv_alu_sig_checker dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .vec_count_i(vec_count_i),
        .seed_i(seed_i), .expected_sig_i(expected_sig_i),
`ifdef ALU_SIG_OPMASK_EN
        .op_mask_i(op_mask),
`endif
        .valid_i(valid_i), .ready_o(ready_o), .alu_op_i(alu_op_i), .alu_a_i(alu_a_i),
        .alu_b_i(alu_b_i), .alu_p_i(alu_p_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .signature_o(signature_o), .vec_done_o(vec_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [3:0] op,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] p);
        logic [31:0] word;
        if (!mask_r[op]) return s;
        word = p ^ ((a << 1) | (a >> 31)) ^ b ^ 32'(op);
        return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ word;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_run(input logic [31:0] seed, input logic [15:0] n, input logic [31:0] exp);
        start_i = 1'b1; seed_i = seed; vec_count_i = n; expected_sig_i = exp;
        tick();
        start_i = 1'b0;
    endtask

    task automatic drive_vec(input logic v, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] p);
        valid_i = v; alu_op_i = op; alu_a_i = a; alu_b_i = b; alu_p_i = p;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        checks++;
        if ({ready_o, busy_o, done_o, pass_o, signature_o, vec_done_o} !== '0) begin
            errors++; $display("FAIL reset_init: got %h required 0", {ready_o, busy_o, done_o, pass_o, signature_o, vec_done_o});
        end
        start_run(32'hDEADBEEF, 16'd5, 32'h1);
        drive_vec(1'b1, 4'h3, 32'h11, 32'h22, 32'h33);
        drive_vec(1'b1, 4'h4, 32'h44, 32'h55, 32'h66);
        rst_i = 1'b0;
        repeat (2) tick();
        checks++;
        if ({ready_o, busy_o, done_o, pass_o, signature_o, vec_done_o} !== '0) begin
            errors++; $display("FAIL reset_midrun: got %h required 0", {ready_o, busy_o, done_o, pass_o, signature_o, vec_done_o});
        end
        rst_i = 1'b1;
        drive_vec(1'b1, 4'h1, 32'h1, 32'h2, 32'h3);
        checks++;
        if ({ready_o, busy_o, done_o, signature_o, vec_done_o} !== '0) begin
            errors++; $display("FAIL idle_drop: got %h required 0", {ready_o, busy_o, done_o, signature_o, vec_done_o});
        end
    endtask

    task automatic test_zero_vectors;
        start_run(32'h12345678, 16'd0, 32'h12345678);
        checks++;
        if ({done_o, pass_o, busy_o, signature_o, vec_done_o} !== {3'b110, 32'h12345678, 16'd0}) begin
            errors++; $display("FAIL zero_pass: got done=%b pass=%b busy=%b sig=%h required 1 1 0 12345678", done_o, pass_o, busy_o, signature_o);
        end
        start_run(32'h12345678, 16'd0, 32'h0);
        checks++;
        if ({done_o, pass_o} !== 2'b10) begin
            errors++; $display("FAIL zero_fail: got done=%b pass=%b required 1 0", done_o, pass_o);
        end
    endtask

    task automatic test_single;
        start_run(32'h0, 16'd1, 32'h1);
        checks++;
        if ({ready_o, busy_o, done_o} !== 3'b110) begin
            errors++; $display("FAIL single_run: got rdy/busy/done=%b required 110", {ready_o, busy_o, done_o});
        end
        drive_vec(1'b1, 4'h0, 32'h0, 32'h0, 32'h1);
        checks++;
        if ({signature_o, done_o, pass_o, ready_o, vec_done_o} !== {32'h1, 3'b110, 16'd1}) begin
            errors++; $display("FAIL single_sig: got sig=%h done=%b pass=%b rdy=%b required 00000001 1 1 0", signature_o, done_o, pass_o, ready_o);
        end
    endtask

    task automatic test_feedback;
        start_run(32'h80000000, 16'd1, 32'h0);
        drive_vec(1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({signature_o, done_o, pass_o} !== {32'h04C11DB7, 2'b10}) begin
            errors++; $display("FAIL feedback: got sig=%h done=%b pass=%b required 04c11db7 1 0", signature_o, done_o, pass_o);
        end
    endtask

    task automatic test_back_to_back_gaps;
        logic [3:0]  op [3];
        logic [31:0] a [3], b [3], p [3];
        logic [31:0] m, held;
        m = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            op[i] = 4'($urandom); a[i] = $urandom; b[i] = $urandom; p[i] = $urandom;
            m = model_step(m, op[i], a[i], b[i], p[i]);
        end
        start_run(32'hCAFEF00D, 16'd3, m);
        drive_vec(1'b1, op[0], a[0], b[0], p[0]);
        start_i = 1'b1; seed_i = 32'h0; vec_count_i = 16'd9; expected_sig_i = 32'h0;
        drive_vec(1'b0, 4'hF, $urandom, $urandom, $urandom);
        start_i = 1'b0;
        drive_vec(1'b1, op[1], a[1], b[1], p[1]);
        checks++;
        if ({done_o, busy_o, vec_done_o} !== {2'b01, 16'd2}) begin
            errors++; $display("FAIL gap_mid: got done=%b busy=%b vec_done=%0d required 0 1 2", done_o, busy_o, vec_done_o);
        end
        drive_vec(1'b0, 4'hF, $urandom, $urandom, $urandom);
        drive_vec(1'b1, op[2], a[2], b[2], p[2]);
        checks++;
        if ({signature_o, vec_done_o, done_o, pass_o} !== {m, 16'd3, 2'b11}) begin
            errors++; $display("FAIL gap_end: got sig=%h vd=%0d done=%b pass=%b required %h 3 1 1", signature_o, vec_done_o, done_o, pass_o, m);
        end
        held = signature_o;
        drive_vec(1'b1, 4'h2, $urandom, $urandom, $urandom);
        checks++;
        if ({signature_o, vec_done_o, done_o, pass_o} !== {held, 16'd3, 2'b11}) begin
            errors++; $display("FAIL done_hold: got sig=%h vd=%0d done=%b pass=%b required %h 3 1 1", signature_o, vec_done_o, done_o, pass_o, held);
        end
    endtask

    task automatic test_random;
        logic [3:0]  op [16];
        logic [31:0] a [16], b [16], p [16], part [17];
        logic [31:0] exp;
        int n;
        for (int r = 0; r < 10; r++) begin
`ifdef ALU_SIG_OPMASK_EN
            mask_r = 16'($urandom);
`endif
            n = $urandom_range(1, 16);
            part[0] = $urandom;
            for (int i = 0; i < n; i++) begin
                op[i] = 4'($urandom); a[i] = $urandom; b[i] = $urandom; p[i] = $urandom;
                part[i+1] = model_step(part[i], op[i], a[i], b[i], p[i]);
            end
            exp = r[0] ? part[n] : $urandom;
            start_run(part[0], 16'(n), exp);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 2) == 0) drive_vec(1'b0, 4'($urandom), $urandom, $urandom, $urandom);
                drive_vec(1'b1, op[i], a[i], b[i], p[i]);
                checks++;
                if ({signature_o, vec_done_o, done_o} !== {part[i+1], 16'(i + 1), i == n - 1}) begin
                    errors++; $display("FAIL rand_step r%0d v%0d: got sig=%h vd=%0d done=%b required %h %0d %b", r, i, signature_o, vec_done_o, done_o, part[i+1], i + 1, i == n - 1);
                end
            end
            checks++;
            if (pass_o !== (part[n] == exp)) begin
                errors++; $display("FAIL rand_pass r%0d: got %b required %b", r, pass_o, part[n] == exp);
            end
        end
        mask_r = 16'hFFFF;
    endtask

`ifdef ALU_SIG_OPMASK_EN
    task automatic test_opmask;
        mask_r = 16'hFFFE;
        start_run(32'h0, 16'd1, 32'h0);
        drive_vec(1'b1, 4'h0, 32'h0, 32'h0, 32'h1);
        checks++;
        if ({signature_o, vec_done_o, done_o, pass_o} !== {32'h0, 16'd1, 2'b11}) begin
            errors++; $display("FAIL opmask: got sig=%h vd=%0d done=%b pass=%b required 0 1 1 1", signature_o, vec_done_o, done_o, pass_o);
        end
        mask_r = 16'hFFFF;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_vectors();
        test_single();
        test_feedback();
        test_back_to_back_gaps();
`ifdef ALU_SIG_OPMASK_EN
        test_opmask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
